// File: rtl/esc_cmd_ramp.sv
// esc_cmd_ramp: arming sequencer and per-frame slew limiter for four ESC speed commands.
// Speed outputs change only on the clock after frm_start; disarm ramps every motor to zero.
//
// Ports:
//   clk, rst                      system clock, async active-high reset
//   frm_start                     one-cycle pulse at each ESC PWM frame wrap
//   arm_req, disarm_req           one-cycle arm / disarm requests
//   cmd_vld                       capture strobe for the four targets
//   frnt_cmd..rght_cmd [10:0]     requested speeds
//   frnt_spd..rght_spd [10:0]     registered speeds to the ESC PWM generators
//   armed                         high only while ARMED
//   ramping                       any speed output differs from its target
module esc_cmd_ramp #(
  parameter logic [10:0] MAX_STEP   = 11'd32,
  parameter logic [10:0] SPD_LIMIT  = 11'd2000,
  parameter logic [7:0]  ARM_FRAMES = 8'd48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_start,
  input  logic        arm_req,
  input  logic        disarm_req,
  input  logic        cmd_vld,
  input  logic [10:0] frnt_cmd,
  input  logic [10:0] bck_cmd,
  input  logic [10:0] lft_cmd,
  input  logic [10:0] rght_cmd,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        armed,
  output logic        ramping
);

  typedef enum logic [1:0] {
    DISARMED,
    ARM_WAIT,
    ARMED,
    DISARM_RAMP
  } state_t;

  localparam logic signed [11:0] STEP_S =
    $signed({1'b0, MAX_STEP});

  state_t state;
  state_t state_nxt;

  logic [7:0] frm_cnt;
  logic [7:0] frm_cnt_nxt;

  // motor order: 0 front, 1 back, 2 left, 3 right
  logic [3:0][10:0] cmd;
  logic [3:0][10:0] tgt;
  logic [3:0][10:0] tgt_nxt;
  logic [3:0][10:0] spd;
  logic [3:0][10:0] spd_nxt;

  assign cmd = {rght_cmd, lft_cmd, bck_cmd, frnt_cmd};

  function automatic logic [10:0] clamp(
    input logic [10:0] c
  );
    return (c > SPD_LIMIT) ? SPD_LIMIT : c;
  endfunction

  // Snap to target when within one step, otherwise
  // move one full step. Targets are clamped, so the
  // result never overshoots or leaves 0..SPD_LIMIT.
  function automatic logic [10:0] slew(
    input logic [10:0] cur,
    input logic [10:0] goal
  );
    logic signed [11:0] diff;
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
    if (diff > STEP_S) begin
      return cur + MAX_STEP;
    end else if (diff < -STEP_S) begin
      return cur - MAX_STEP;
    end else begin
      return goal;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DISARMED;
      frm_cnt <= '0;
      tgt     <= '0;
      spd     <= '0;
    end else begin
      state   <= state_nxt;
      frm_cnt <= frm_cnt_nxt;
      tgt     <= tgt_nxt;
      spd     <= spd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frm_cnt_nxt = frm_cnt;
    tgt_nxt     = tgt;
    spd_nxt     = spd;
    unique case (state)
      DISARMED: begin
        tgt_nxt = '0;
        spd_nxt = '0;
        if (arm_req && !disarm_req) begin
          state_nxt   = ARM_WAIT;
          frm_cnt_nxt = '0;
        end
      end
      ARM_WAIT: begin
        tgt_nxt = '0;
        spd_nxt = '0;
        if (disarm_req) begin
          state_nxt = DISARMED;
        end else if (frm_start) begin
          frm_cnt_nxt = frm_cnt + 8'd1;
          if (frm_cnt == ARM_FRAMES - 8'd1) begin
            state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        // step reads the registered target, so a
        // same-cycle capture applies next frame
        if (frm_start) begin
          for (int i = 0; i < 4; i++) begin
            spd_nxt[i] = slew(spd[i], tgt[i]);
          end
        end
        if (disarm_req) begin
          tgt_nxt   = '0;
          state_nxt = DISARM_RAMP;
        end else if (cmd_vld) begin
          for (int i = 0; i < 4; i++) begin
            tgt_nxt[i] = clamp(cmd[i]);
          end
        end
      end
      DISARM_RAMP: begin
        if (frm_start) begin
          for (int i = 0; i < 4; i++) begin
            spd_nxt[i] = slew(spd[i], tgt[i]);
          end
        end
        if (spd == '0) begin
          state_nxt = DISARMED;
        end
      end
      default: begin
        state_nxt = DISARMED;
      end
    endcase
  end

  assign frnt_spd = spd[0];
  assign bck_spd  = spd[1];
  assign lft_spd  = spd[2];
  assign rght_spd = spd[3];

  assign armed   = (state == ARMED);
  assign ramping = (spd != tgt);

endmodule

// File: tb/tb_esc_cmd_ramp.sv
// tb_esc_cmd_ramp: scoreboard bench for esc_cmd_ramp.
// Stimulus queues expected outputs; a monitor pops and compares them.
module tb_esc_cmd_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frm_start = 1'b0;
  logic        arm_req = 1'b0;
  logic        disarm_req = 1'b0;
  logic        cmd_vld = 1'b0;
  logic [10:0] frnt_cmd = '0;
  logic [10:0] bck_cmd = '0;
  logic [10:0] lft_cmd = '0;
  logic [10:0] rght_cmd = '0;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        armed;
  logic        ramping;

  logic chk = 1'b0;
  logic chk_now = 1'b0;
  logic frm_q = 1'b0;
  logic chk_q = 1'b0;

  typedef struct {
    logic [10:0] f;
    logic [10:0] b;
    logic [10:0] l;
    logic [10:0] r;
    logic        a;
    logic        rp;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  always #10 clk = ~clk;

  esc_cmd_ramp dut (
    .clk        (clk),
    .rst        (rst),
    .frm_start  (frm_start),
    .arm_req    (arm_req),
    .disarm_req (disarm_req),
    .cmd_vld    (cmd_vld),
    .frnt_cmd   (frnt_cmd),
    .bck_cmd    (bck_cmd),
    .lft_cmd    (lft_cmd),
    .rght_cmd   (rght_cmd),
    .frnt_spd   (frnt_spd),
    .bck_spd    (bck_spd),
    .lft_spd    (lft_spd),
    .rght_spd   (rght_spd),
    .armed      (armed),
    .ramping    (ramping)
  );

  always @(posedge clk) begin
    frm_q <= frm_start;
    chk_q <= chk;
  end

  always @(negedge clk) begin
    if (frm_q || chk_q || chk_now) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unqueued: output event with no expectation");
      end else begin
        exp_t  e;
        string n;
        e = q.pop_front();
        n = nq.pop_front();
        if (frnt_spd !== e.f || bck_spd !== e.b ||
            lft_spd !== e.l || rght_spd !== e.r ||
            armed !== e.a || ramping !== e.rp) begin
          errors++;
          $display("FAIL %s: got %0d/%0d/%0d/%0d a=%b rp=%b want %0d/%0d/%0d/%0d a=%b rp=%b",
                   n, frnt_spd, bck_spd, lft_spd, rght_spd,
                   armed, ramping, e.f, e.b, e.l, e.r,
                   e.a, e.rp);
        end
      end
    end
  end

  task automatic expect_out(
    input string n,
    input int f, input int b,
    input int l, input int r,
    input bit a, input bit rp
  );
    exp_t e;
    e.f  = 11'(f);
    e.b  = 11'(b);
    e.l  = 11'(l);
    e.r  = 11'(r);
    e.a  = a;
    e.rp = rp;
    q.push_back(e);
    nq.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    frm_start  = 1'b0;
    arm_req    = 1'b0;
    disarm_req = 1'b0;
    cmd_vld    = 1'b0;
    chk        = 1'b0;
    chk_now    = 1'b0;
  endtask

  task automatic frame(
    input string n,
    input int f, input int b,
    input int l, input int r,
    input bit a, input bit rp
  );
    expect_out(n, f, b, l, r, a, rp);
    frm_start = 1'b1;
    step();
    step();
  endtask

  task automatic set_cmd(
    input int f, input int b,
    input int l, input int r
  );
    frnt_cmd = 11'(f);
    bck_cmd  = 11'(b);
    lft_cmd  = 11'(l);
    rght_cmd = 11'(r);
    cmd_vld  = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int v;
    int f;
    int l;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    chk_now = 1'b1;
    step();
    rst = 1'b0;
    step();

    arm_req    = 1'b1;
    disarm_req = 1'b1;
    chk        = 1'b1;
    expect_out("arm_dis_same", 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 1; k <= 48; k++)
      frame("stay_disarmed", 0, 0, 0, 0, 0, 0);

    arm_req = 1'b1;
    step();
    for (int k = 1; k <= 10; k++)
      frame("arm_wait", 0, 0, 0, 0, 0, 0);
    disarm_req = 1'b1;
    chk        = 1'b1;
    expect_out("wait_disarm", 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 1; k <= 48; k++)
      frame("after_wait_disarm", 0, 0, 0, 0, 0, 0);

    arm_req = 1'b1;
    step();
    for (int k = 1; k <= 48; k++)
      frame("arming", 0, 0, 0, 0, k == 48, 0);

    set_cmd(100, 0, 0, 0);
    chk = 1'b1;
    expect_out("cap100", 0, 0, 0, 0, 1, 1);
    step();
    frame("up32", 32, 0, 0, 0, 1, 1);
    frame("up64", 64, 0, 0, 0, 1, 1);
    frame("up96", 96, 0, 0, 0, 1, 1);
    frame("up100", 100, 0, 0, 0, 1, 0);

    set_cmd(100, 2047, 0, 0);
    chk = 1'b1;
    expect_out("cap2047", 100, 0, 0, 0, 1, 1);
    step();
    for (int k = 1; k <= 63; k++) begin
      v = (32 * k > 2000) ? 2000 : 32 * k;
      frame("clamp_up", 100, v, 0, 0, 1, k < 63);
    end

    set_cmd(100, 10, 0, 0);
    step();
    v = 2000;
    for (int k = 1; k <= 63; k++) begin
      v = (v - 10 > 32) ? v - 32 : 10;
      frame("down10", 100, v, 0, 0, 1, k < 63);
    end

    set_cmd(100, 10, 64, 0);
    frm_start = 1'b1;
    expect_out("cmd_frm_same", 100, 10, 0, 0, 1, 1);
    step();
    step();
    frame("lft32", 100, 10, 32, 0, 1, 1);
    frame("lft64", 100, 10, 64, 0, 1, 0);

    set_cmd(500, 0, 70, 31);
    step();
    for (int k = 1; k <= 13; k++) begin
      v = (100 + 32 * k > 500) ? 500 : 100 + 32 * k;
      frame("to500", v, 0, 70, 31, 1, k < 13);
    end

    disarm_req = 1'b1;
    chk        = 1'b1;
    expect_out("disarm", 500, 0, 70, 31, 0, 1);
    step();
    set_cmd(2000, 2000, 2000, 2000);
    chk = 1'b1;
    expect_out("ramp_cmd_ignored", 500, 0, 70, 31, 0, 1);
    step();
    f = 500;
    l = 70;
    for (int k = 1; k <= 16; k++) begin
      f = (f > 32) ? f - 32 : 0;
      l = (l > 32) ? l - 32 : 0;
      frame("disarm_ramp", f, 0, l, 0, 0, k < 16);
    end
    step();

    arm_req = 1'b1;
    step();
    for (int k = 1; k <= 48; k++)
      frame("rearm", 0, 0, 0, 0, k == 48, 0);
    set_cmd(300, 0, 0, 0);
    step();
    frame("re_up32", 32, 0, 0, 0, 1, 1);
    frame("re_up64", 64, 0, 0, 0, 1, 1);
    frame("re_up96", 96, 0, 0, 0, 1, 1);

    #4;
    rst     = 1'b1;
    chk_now = 1'b1;
    expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    set_cmd(500, 500, 500, 500);
    chk = 1'b1;
    expect_out("cmd_unarmed", 0, 0, 0, 0, 0, 0);
    step();
    for (int k = 1; k <= 3; k++)
      frame("unarmed_frame", 0, 0, 0, 0, 0, 0);

    repeat (3) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esc_cmd_ramp.md
# esc_cmd_ramp

Command conditioner between the flight controller and the four ESC PWM generators. Captures per-motor speed targets, runs an ESC arming sequence, and slews each motor's 11-bit SPEED output toward its target by at most one step per PWM frame. Updates land only on frame boundaries, so an ESC never sees a width change mid-pulse. On disarm it ramps all motors down to zero before returning idle.

## Interface
- MAX_STEP, 11'd32: largest per-frame change of any speed output, in SPEED LSBs.
- SPD_LIMIT, 11'd2000: captured targets above this are clamped to it.
- ARM_FRAMES, 8'd48: frames held at zero speed after arm request (48 × 20.97 ms ≈ 1 s); legal range 1..255.

- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- frm_start  in  1  single-cycle pulse at each ESC PWM period wrap (once per 2^20 clocks).
- arm_req  in  1  single-cycle arm request.
- disarm_req  in  1  single-cycle disarm request.
- cmd_vld  in  1  capture strobe for the four targets.
- frnt_cmd, bck_cmd, lft_cmd, rght_cmd  in  11 each  requested motor speeds.
- frnt_spd, bck_spd, lft_spd, rght_spd  out  11 each  registered SPEED to ESC interfaces.
- armed  out  1  high only in ARMED.
- ramping  out  1  high when any speed output differs from its target.

## Operation
- States: DISARMED, ARM_WAIT, ARMED, DISARM_RAMP.
- DISARMED: all outputs and targets held at 0. arm_req moves to ARM_WAIT and clears the 8-bit frame counter.
- ARM_WAIT: outputs stay 0. Each frm_start increments the frame counter. On the frm_start where the counter equals ARM_FRAMES-1, the block moves to ARMED. disarm_req returns it to DISARMED immediately.
- ARMED: cmd_vld captures all four targets, each as min(cmd, SPD_LIMIT). On each frm_start, every output moves toward its target:
  - if |target − out| ≤ MAX_STEP, out becomes target;
  - otherwise out moves by exactly ±MAX_STEP.
  - Use 12-bit signed difference arithmetic. Outputs never wrap and never leave the range 0..SPD_LIMIT.
- ARMED + disarm_req: all targets forced to 0; state moves to DISARM_RAMP.
- DISARM_RAMP: ramps down by the same rule. cmd_vld and arm_req are ignored. When all four outputs are 0, state moves to DISARMED on the next clock.
- Priorities:
  - disarm_req beats arm_req in the same cycle.
  - cmd_vld is ignored outside ARMED.
  - arm_req outside DISARMED is ignored.
- cmd_vld and frm_start in the same cycle: the step uses the old target. The new target takes effect on the next frame.
- ramping = OR over the four motors of (out ≠ target). It is combinational from registers.

## Timing
- Reset: state DISARMED, all speeds 0, targets 0, frame counter 0, armed 0, ramping 0.
- Reset mid-operation: outputs drop to 0 asynchronously. No ramp-down is performed.
- Targets register on the clock edge where cmd_vld is high.
- Speed outputs change only on the clock edge following frm_start (1-cycle latency). They hold at all other cycles.
- armed rises on the edge that enters ARMED and falls on the edge that leaves it.
- From arm_req to armed: ARM_FRAMES frm_start pulses.
- Worst-case ramp from 0 to SPD_LIMIT: ceil(SPD_LIMIT / MAX_STEP) frames (63 at defaults).

## Test plan
- Reset then arm: arm_req, then 48 frm_start pulses → armed rises after the 48th pulse; all speeds read 0 throughout.
- Ramp up: armed, cmd_vld with frnt_cmd = 100 → frnt_spd reads 32, 64, 96, 100 over four frames, then ramping = 0; other motors stay 0.
- Clamp and ramp down: cmd 2047 → target 2000, reached in 63 frames. Then cmd 10 → output decreases by 32 per frame, ending exactly at 10.
- Disarm: at speeds 500/0/70/31, disarm_req → armed falls and DISARM_RAMP is entered; cmd_vld is ignored. All outputs reach 0 after 16 frames; DISARMED is entered one cycle later.
- Corner cases:
  - arm_req and disarm_req in the same cycle → stays DISARMED.
  - disarm_req in ARM_WAIT → DISARMED immediately.
  - cmd_vld coincident with frm_start → step toward the old target.
- Reset mid-ramp: assert rst while speeds are nonzero → outputs 0 immediately, state DISARMED; a later cmd_vld without arming has no effect.
